// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding and
// width helpers used to size the select and hold-counter registers.
package mux_arb_defs;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Select width for n requesters; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter width; one spare bit so MAX_HOLD-1 always fits.
  function automatic int hold_width(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so that
// the pointer position lands at bit 0, then priority-encodes the lowest
// set bit and rotates the result back into an absolute requester index.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] winner,
  output logic          any
);

  logic [N-1:0]  rot;
  logic [SW-1:0] offset;

  // Doubling the vector lets a plain right shift act as a rotate.
  assign rot = N'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the first requester at or after ptr.
  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) offset = SW'(i);
    end
  end

  // N is a power of two, so the SW-bit add wraps modulo N for free.
  assign winner = ptr + offset;
  assign any    = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a shared N-input mux. Grants one
// requester at a time for up to MAX_HOLD cycles, drives the mux select
// and registers the selected data beat with a valid flag.
module mux_rr_arbiter
  import mux_arb_defs::*;
#(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  // Derived from N; leave at its default.
  parameter int SW       = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   din,
  output logic [N-1:0]         gnt,
  output logic [SW-1:0]        sel,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid
);

  localparam int            HW        = hold_width(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic [SW-1:0]     winner;
  logic              any_req;
  logic              release_now;
  logic              xfer;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  // All state, including the output beat, resets immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      hold_cnt_q   <= '0;
      gnt_q        <= '0;
      sel_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Next state: arbitrate from IDLE, or on release while granted; since ptr sits
  // one past the owner, the owner only wins again when it is the sole requester.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    release_now = !req[sel_q] || (hold_cnt_q == HOLD_LAST);
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d        = GRANT;
          ptr_d          = winner + 1'b1;
          hold_cnt_d     = '0;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          sel_d          = winner;
        end
      end
      GRANT: begin
        if (release_now) begin
          if (any_req) begin
            ptr_d          = winner + 1'b1;
            hold_cnt_d     = '0;
            gnt_d          = '0;
            gnt_d[winner]  = 1'b1;
            sel_d          = winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output beat: capture the selected lane whenever the owner is still requesting.
  always_comb begin
    xfer         = gnt_q[sel_q] && req[sel_q];
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (xfer) begin
      dout_d       = din[sel_q*WIDTH +: WIDTH];
      dout_valid_d = 1'b1;
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with N=4, WIDTH=8, MAX_HOLD=4.
module tb_mux_rr_arbiter;

  localparam int N        = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       gnt;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       dv;
  } vec_t;

  vec_t vecs[21];
  logic [7:0] lane[4];

  mux_rr_arbiter #(
    .N        (N),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] e_gnt,
                             input logic [1:0] e_sel, input logic [7:0] e_dout,
                             input logic e_dv);
    vec_count++;
    if (gnt !== e_gnt || sel !== e_sel || dout !== e_dout || dout_valid !== e_dv) begin
      miss_count++;
      $display("[TB] FAIL %s: got gnt=%b sel=%0d dout=%h valid=%b, expected gnt=%b sel=%0d dout=%h valid=%b",
               name, gnt, sel, dout, dout_valid, e_gnt, e_sel, e_dout, e_dv);
    end
  endtask

  // Present a request vector, clock one edge, then settle before sampling.
  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_state", 4'b0000, 2'd0, 8'h00, 1'b0);
  endtask

  initial begin
    lane[0] = 8'h10;
    lane[1] = 8'h21;
    lane[2] = 8'hA5;
    lane[3] = 8'h3C;
    din     = {lane[3], lane[2], lane[1], lane[0]};
    reset   = 1'b0;
    req     = '0;

    // Single requester, idle return, early release, wrap-around.
    vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 8'h00, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1};
    vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1};
    vecs[3]  = '{4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1};
    vecs[4]  = '{4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1};
    vecs[5]  = '{4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1};
    vecs[6]  = '{4'b0000, 4'b0000, 2'd2, 8'hA5, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 2'd2, 8'hA5, 1'b0};
    vecs[8]  = '{4'b0010, 4'b0010, 2'd1, 8'hA5, 1'b0};
    vecs[9]  = '{4'b1010, 4'b0010, 2'd1, 8'h21, 1'b1};
    vecs[10] = '{4'b1010, 4'b0010, 2'd1, 8'h21, 1'b1};
    vecs[11] = '{4'b1000, 4'b1000, 2'd3, 8'h21, 1'b0};
    vecs[12] = '{4'b1000, 4'b1000, 2'd3, 8'h3C, 1'b1};
    vecs[13] = '{4'b1001, 4'b1000, 2'd3, 8'h3C, 1'b1};
    vecs[14] = '{4'b1001, 4'b1000, 2'd3, 8'h3C, 1'b1};
    vecs[15] = '{4'b1001, 4'b0001, 2'd0, 8'h3C, 1'b1};
    vecs[16] = '{4'b1001, 4'b0001, 2'd0, 8'h10, 1'b1};
    vecs[17] = '{4'b1001, 4'b0001, 2'd0, 8'h10, 1'b1};
    vecs[18] = '{4'b1001, 4'b0001, 2'd0, 8'h10, 1'b1};
    vecs[19] = '{4'b1001, 4'b1000, 2'd3, 8'h10, 1'b1};
    vecs[20] = '{4'b1001, 4'b1000, 2'd3, 8'h3C, 1'b1};

    $display("[TB] directed table");
    doReset();
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("table[%0d]", i), vecs[i].gnt, vecs[i].sel,
                  vecs[i].dout, vecs[i].dv);
    end

    // All four requesting: strict rotation, MAX_HOLD cycles per owner, no bubbles.
    $display("[TB] fairness");
    doReset();
    for (int e = 1; e <= 32; e++) begin
      int owner;
      int prev_owner;
      owner = ((e - 1) / MAX_HOLD) % N;
      applyStimulus(4'b1111);
      if (e == 1) begin
        checkOutput("fair[1]", 4'b0001, 2'd0, 8'h00, 1'b0);
      end else begin
        prev_owner = ((e - 2) / MAX_HOLD) % N;
        checkOutput($sformatf("fair[%0d]", e), 4'(1 << owner), 2'(owner),
                    lane[prev_owner], 1'b1);
      end
    end

    // Asynchronous reset in the middle of a tenure, then fresh arbitration.
    $display("[TB] reset mid-tenure");
    doReset();
    applyStimulus(4'b0100);
    applyStimulus(4'b0100);
    checkOutput("pre_async_reset", 4'b0100, 2'd2, 8'hA5, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 4'b0000, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0101;
    @(posedge clk);
    #1;
    checkOutput("post_reset_pick0", 4'b0001, 2'd0, 8'h00, 1'b0);
    repeat (3) applyStimulus(4'b0101);
    checkOutput("post_reset_hold", 4'b0001, 2'd0, 8'h10, 1'b1);
    applyStimulus(4'b0101);
    checkOutput("post_reset_next2", 4'b0100, 2'd2, 8'h10, 1'b1);
    applyStimulus(4'b0101);
    checkOutput("post_reset_beat2", 4'b0100, 2'd2, 8'hA5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
